// File: rtl/pixel_scan_ctrl.sv
// Pixel mux scan sequencer: walks a window of mux indices (up/down, wrapping modulo NUM_PIX)
// and streams each selected pixel over a valid/ready handshake with full backpressure.
`ifndef PIX_WIDTH
`define PIX_WIDTH 8
`endif

module pixel_scan_ctrl #(
    parameter int unsigned NUM_PIX = 50,
    parameter int unsigned SEL_W   = 6,
    parameter int unsigned PIX_W   = `PIX_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [SEL_W-1:0] Start_Index,
    input  logic [SEL_W-1:0] Count,
    input  logic             Direction,
    input  logic             Abort,
    output logic [SEL_W-1:0] Pixel_Select,
    input  logic [PIX_W-1:0] Selected_Pixel,
    output logic [PIX_W-1:0] Out_Pixel,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic             Busy,
    output logic             Done,
    output logic             Err
);

    typedef enum logic [1:0] {StIdle, StScan, StDrain} state_e;

    localparam logic [SEL_W-1:0] LastIdx    = SEL_W'(NUM_PIX - 1);
    localparam logic [SEL_W:0]   NumPixExt  = (SEL_W + 1)'(NUM_PIX);
    localparam logic [SEL_W-1:0] OneW       = SEL_W'(1);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   rem_q, rem_d;
    logic               dir_q, dir_d;
    logic [PIX_W-1:0]   pix_q, pix_d;
    logic               valid_q, valid_d;
    logic               busy_q, done_q, done_d, err_q, err_d;

    logic               cfg_ok;
    logic               slot_free;
    logic               last_pix;
    logic [SEL_W-1:0]   next_idx;

    assign cfg_ok    = ({1'b0, Start_Index} < NumPixExt) && (Count != '0) &&
                       ({1'b0, Count} <= NumPixExt);
    assign slot_free = !valid_q || Out_Ready;
    assign last_pix  = (rem_q == OneW);

    always_comb begin
        if (dir_q) begin
            next_idx = (sel_q == '0) ? LastIdx : sel_q - OneW;
        end else begin
            next_idx = (sel_q == LastIdx) ? '0 : sel_q + OneW;
        end
    end

    // State register and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            sel_q   <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            pix_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            pix_q   <= pix_d;
            valid_q <= valid_d;
            busy_q  <= (state_d != StIdle);
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (Start && !Abort && cfg_ok) state_d = StScan;
            end
            StScan: begin
                if (Abort) begin
                    state_d = StIdle;
                end else if (slot_free && last_pix) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (Abort || (valid_q && Out_Ready)) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        sel_d   = sel_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        pix_d   = pix_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (Start && !Abort) begin
                    if (cfg_ok) begin
                        sel_d = Start_Index;
                        rem_d = Count;
                        dir_d = Direction;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StScan: begin
                if (Abort) begin
                    valid_d = 1'b0;
                    rem_d   = '0;
                end else if (slot_free) begin
                    pix_d   = Selected_Pixel;
                    valid_d = 1'b1;
                    rem_d   = rem_q - OneW;
                    // Select stays on the final index once the window is exhausted
                    if (!last_pix) sel_d = next_idx;
                end
            end
            StDrain: begin
                if (Abort) begin
                    valid_d = 1'b0;
                end else if (valid_q && Out_Ready) begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: valid_d = 1'b0;
        endcase
    end

    assign Pixel_Select = sel_q;
    assign Out_Pixel    = pix_q;
    assign Out_Valid    = valid_q;
    assign Busy         = busy_q;
    assign Done         = done_q;
    assign Err          = err_q;

endmodule

// File: tb/tb_pixel_scan_ctrl.sv
// Directed bench for pixel_scan_ctrl: pixel i of the mux model is i+100; expected pixels are
// queued at Start and popped on every accepted handshake.
module tb_pixel_scan_ctrl;

    localparam int PIX_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             Start;
    logic [5:0]       Start_Index;
    logic [5:0]       Count;
    logic             Direction;
    logic             Abort;
    logic [5:0]       Pixel_Select;
    logic [PIX_W-1:0] Selected_Pixel;
    logic [PIX_W-1:0] Out_Pixel;
    logic             Out_Valid;
    logic             Out_Ready;
    logic             Busy;
    logic             Done;
    logic             Err;

    int               total  = 0;
    int               passed = 0;
    logic [PIX_W-1:0] exp_q[$];
    logic             prev_stall = 1'b0;
    logic [PIX_W-1:0] prev_pix   = '0;

    pixel_scan_ctrl #(
        .NUM_PIX (50),
        .SEL_W   (6),
        .PIX_W   (PIX_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .Start          (Start),
        .Start_Index    (Start_Index),
        .Count          (Count),
        .Direction      (Direction),
        .Abort          (Abort),
        .Pixel_Select   (Pixel_Select),
        .Selected_Pixel (Selected_Pixel),
        .Out_Pixel      (Out_Pixel),
        .Out_Valid      (Out_Valid),
        .Out_Ready      (Out_Ready),
        .Busy           (Busy),
        .Done           (Done),
        .Err            (Err)
    );

    always #5 clk = ~clk;

    assign Selected_Pixel = (Pixel_Select < 6'd50) ? PIX_W'(Pixel_Select + 8'd100) : 8'hEE;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_scan(input int idx, input int cnt, input bit dir);
        int p = idx;
        for (int k = 0; k < cnt; k++) begin
            exp_q.push_back(PIX_W'(p + 100));
            if (dir) p = (p == 0) ? 49 : p - 1;
            else     p = (p == 49) ? 0 : p + 1;
        end
        Start       = 1'b1;
        Start_Index = 6'(idx);
        Count       = 6'(cnt);
        Direction   = dir;
        step();
        Start = 1'b0;
    endtask

    // Runs until Done (bounded); Out_Ready follows pat per cycle, then stays high.
    task automatic wait_done(input int max_cyc, input logic [15:0] pat, output int n,
                             output int busy_cyc);
        n        = 0;
        busy_cyc = 0;
        while (Done !== 1'b1 && n < max_cyc) begin
            Out_Ready = (n < 16) ? pat[n] : 1'b1;
            if (Busy === 1'b1) busy_cyc++;
            step();
            n++;
        end
        chk("done_seen", 32'(Done), 1);
        Out_Ready = 1'b1;
    endtask

    // Handshake monitor: scoreboard pops on accept, output must hold while stalled.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall <= 1'b0;
        end else begin
            chk("sel_range", 32'(Pixel_Select < 6'd50), 1);
            if (prev_stall) begin
                chk("stall_valid", 32'(Out_Valid), 1);
                chk("stall_pixel", 32'(Out_Pixel), 32'(prev_pix));
            end
            if (Out_Valid && Out_Ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pixel", 32'(Out_Pixel), 32'hFFFF_FFFF);
                end else begin
                    chk("pixel", 32'(Out_Pixel), 32'(exp_q.pop_front()));
                end
            end
            prev_stall <= Out_Valid && !Out_Ready && !Abort;
            prev_pix   <= Out_Pixel;
        end
    end

    initial begin
        int n;
        int b;
        int bad_idx[3] = '{50, 3, 3};
        int bad_cnt[3] = '{1, 0, 51};

        reset       = 1'b1;
        Start       = 1'b0;
        Start_Index = '0;
        Count       = '0;
        Direction   = 1'b0;
        Abort       = 1'b0;
        Out_Ready   = 1'b1;
        repeat (3) step();
        chk("rst_sel", 32'(Pixel_Select), 0);
        chk("rst_pix", 32'(Out_Pixel), 0);
        chk("rst_valid", 32'(Out_Valid), 0);
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_done", 32'(Done), 0);
        chk("rst_err", 32'(Err), 0);
        reset = 1'b0;
        step();

        // Basic ascending window with full throughput
        start_scan(3, 4, 1'b0);
        chk("t1_sel", 32'(Pixel_Select), 3);
        chk("t1_busy", 32'(Busy), 1);
        wait_done(20, 16'hFFFF, n, b);
        chk("t1_done_lat", 32'(n), 5);
        chk("t1_busy_cyc", 32'(b), 5);
        chk("t1_q_empty", 32'(exp_q.size()), 0);
        step();
        chk("t1_done_pulse", 32'(Done), 0);
        chk("t1_busy_end", 32'(Busy), 0);

        // Wrap-around both directions
        start_scan(48, 5, 1'b0);
        wait_done(20, 16'hFFFF, n, b);
        chk("t2a_done_lat", 32'(n), 6);
        chk("t2a_q_empty", 32'(exp_q.size()), 0);
        step();
        start_scan(1, 5, 1'b1);
        wait_done(20, 16'hFFFF, n, b);
        chk("t2b_done_lat", 32'(n), 6);
        chk("t2b_q_empty", 32'(exp_q.size()), 0);
        step();

        // Backpressure with Out_Ready 1,0,0,1,0,1
        start_scan(10, 3, 1'b0);
        wait_done(30, 16'hFFE9, n, b);
        chk("t3_q_empty", 32'(exp_q.size()), 0);
        step();

        // Rejected configurations
        for (int i = 0; i < 3; i++) begin
            Start       = 1'b1;
            Start_Index = 6'(bad_idx[i]);
            Count       = 6'(bad_cnt[i]);
            step();
            Start = 1'b0;
            chk("t4_err", 32'(Err), 1);
            chk("t4_busy", 32'(Busy), 0);
            step();
            chk("t4_err_pulse", 32'(Err), 0);
            chk("t4_no_valid", 32'(Out_Valid), 0);
        end
        // Abort beats Start, valid or not
        Start = 1'b1; Abort = 1'b1; Start_Index = 6'd50; Count = 6'd1;
        step();
        chk("t4_abort_no_err", 32'(Err), 0);
        Start_Index = 6'd5;
        step();
        Start = 1'b0; Abort = 1'b0;
        chk("t4_abort_no_busy", 32'(Busy), 0);
        chk("t4_abort_no_valid", 32'(Out_Valid), 0);
        // Start while busy is ignored
        start_scan(20, 3, 1'b0);
        Start = 1'b1; Start_Index = 6'd0; Count = 6'd1;
        step();
        Start = 1'b0;
        chk("t4_busy_start_err", 32'(Err), 0);
        wait_done(20, 16'hFFFF, n, b);
        chk("t4_busy_done_lat", 32'(n), 3);
        chk("t4_q_empty", 32'(exp_q.size()), 0);
        step();

        // Abort after two accepts
        start_scan(5, 8, 1'b0);
        repeat (3) step();
        Out_Ready = 1'b0;
        Abort     = 1'b1;
        step();
        Abort     = 1'b0;
        chk("t5_valid", 32'(Out_Valid), 0);
        chk("t5_busy", 32'(Busy), 0);
        chk("t5_accepted", 32'(exp_q.size()), 6);
        exp_q.delete();
        Out_Ready = 1'b1;
        step();
        chk("t5_no_done", 32'(Done), 0);
        start_scan(0, 2, 1'b1);
        wait_done(20, 16'hFFFF, n, b);
        chk("t5_restart_lat", 32'(n), 3);
        chk("t5_q_empty", 32'(exp_q.size()), 0);
        step();

        // Reset while draining under backpressure
        Out_Ready = 1'b0;
        start_scan(30, 1, 1'b0);
        step();
        step();
        chk("t6_stalled_valid", 32'(Out_Valid), 1);
        chk("t6_stalled_busy", 32'(Busy), 1);
        reset = 1'b1;
        step();
        chk("t6_sel", 32'(Pixel_Select), 0);
        chk("t6_pix", 32'(Out_Pixel), 0);
        chk("t6_valid", 32'(Out_Valid), 0);
        chk("t6_busy", 32'(Busy), 0);
        chk("t6_done", 32'(Done), 0);
        chk("t6_err", 32'(Err), 0);
        exp_q.delete();
        reset     = 1'b0;
        Out_Ready = 1'b1;
        step();
        chk("t6_no_done", 32'(Done), 0);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
